// File: rtl/iiitb_4bbc_sweep_ctrl_if.sv
// Control/status bundle between the LA/wishbone side and the count sweep sequencer.
interface iiitb_4bbc_sweep_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 8,
  parameter int REP_W   = 4
);
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   cfg_start;
  logic [WIDTH-1:0]   cfg_end;
  logic               cfg_up;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [REP_W-1:0]   cfg_repeats;
  logic [WIDTH-1:0]   Count;
  logic               UpOrDown;
  logic               busy;
  logic               done;
  logic               pass_pulse;
  logic [REP_W-1:0]   rep_left;

  modport master (
    output start, stop, cfg_start, cfg_end, cfg_up, cfg_dwell, cfg_repeats,
    input  Count, UpOrDown, busy, done, pass_pulse, rep_left
  );

  modport slave (
    input  start, stop, cfg_start, cfg_end, cfg_up, cfg_dwell, cfg_repeats,
    output Count, UpOrDown, busy, done, pass_pulse, rep_left
  );
endinterface

// File: rtl/iiitb_4bbc_sweep_ctrl.sv
// Sweep sequencer owning the up/down count register: start->end sweeps with dwell and repeats.
// Optional ping-pong passes are enabled by defining IIITB_4BBC_SWEEP_BOUNCE_EN.
//
// state | meaning
// IDLE  | waiting for start; after reset or after stop
// RUN   | sweeping; busy=1
// DONE  | all passes complete; done=1 until next start
module iiitb_4bbc_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 8,
  parameter int REP_W   = 4
) (
  input logic Clk,
  input logic reset_n,
  iiitb_4bbc_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0]   CNT_ONE   = 1;
  localparam logic [DWELL_W-1:0] DWELL_ONE = 1;
  localparam logic [REP_W-1:0]   REP_ONE   = 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   count, sh_start, sh_end;
  logic [DWELL_W-1:0] dwell_cnt, sh_dwell;
  logic [REP_W-1:0]   rep_left;
  logic               up, busy, done, pass_pulse;
  logic               launch, dwell_dec, advance, next_pass, finish;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    dwell_dec = 1'b0;
    advance   = 1'b0;
    next_pass = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // stop outranks everything in RUN, including a pass completing this cycle
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (dwell_cnt != '0) begin
          dwell_dec = 1'b1;
        end else if (count != sh_end) begin
          advance = 1'b1;
        end else if (rep_left == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          next_pass = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      up         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_pulse <= 1'b0;
      rep_left   <= '0;
      dwell_cnt  <= '0;
      sh_start   <= '0;
      sh_end     <= '0;
      sh_dwell   <= '0;
    end else begin
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      pass_pulse <= finish | next_pass;
      if (launch) begin
        sh_start  <= bus.cfg_start;
        sh_end    <= bus.cfg_end;
        sh_dwell  <= bus.cfg_dwell;
        count     <= bus.cfg_start;
        up        <= bus.cfg_up;
        rep_left  <= bus.cfg_repeats;
        dwell_cnt <= bus.cfg_dwell;
      end else if (dwell_dec) begin
        dwell_cnt <= dwell_cnt - DWELL_ONE;
      end else if (advance) begin
        count     <= up ? count + CNT_ONE : count - CNT_ONE;
        dwell_cnt <= sh_dwell;
      end else if (next_pass) begin
        rep_left  <= rep_left - REP_ONE;
        dwell_cnt <= sh_dwell;
`ifdef IIITB_4BBC_SWEEP_BOUNCE_EN
        // turn around on the end value so it is not visited twice in a row
        if (sh_start != sh_end) begin
          sh_start <= sh_end;
          sh_end   <= sh_start;
          up       <= ~up;
          count    <= up ? count - CNT_ONE : count + CNT_ONE;
        end else begin
          count <= sh_start;
        end
`else
        count <= sh_start;
`endif
      end
    end
  end

  assign bus.Count      = count;
  assign bus.UpOrDown   = up;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass_pulse = pass_pulse;
  assign bus.rep_left   = rep_left;

endmodule

// File: tb/tb_iiitb_4bbc_sweep_ctrl.sv
// Directed self-checking bench for the count sweep sequencer.
module tb_iiitb_4bbc_sweep_ctrl;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  iiitb_4bbc_sweep_ctrl_if #(.WIDTH(4), .DWELL_W(8), .REP_W(4)) bus ();

  iiitb_4bbc_sweep_ctrl #(.WIDTH(4), .DWELL_W(8), .REP_W(4)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic set_cfg(input logic [3:0] s, input logic [3:0] e, input logic u,
                         input logic [7:0] d, input logic [3:0] r);
    bus.cfg_start   = s;
    bus.cfg_end     = e;
    bus.cfg_up      = u;
    bus.cfg_dwell   = d;
    bus.cfg_repeats = r;
  endtask

  // leaves the bench at the negedge right after the launching edge
  task automatic pulse_start();
    @(negedge Clk) bus.start = 1'b1;
    @(negedge Clk) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    n_checks++; if (bus.Count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.Count); end
    n_checks++; if (bus.UpOrDown !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b want 1", bus.UpOrDown); end
    n_checks++; if ({bus.busy, bus.done, bus.pass_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.pass_pulse}); end
    n_checks++; if (bus.rep_left !== 4'd0) begin n_fail++; $display("FAIL reset_rep got %0d want 0", bus.rep_left); end
    @(negedge Clk) reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_up_sweep();
    set_cfg(4'd3, 4'd6, 1'b1, 8'd0, 4'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.Count !== 4'(3 + i) || bus.busy !== 1'b1) begin n_fail++; $display("FAIL up_seq[%0d] got count=%0d busy=%b want count=%0d busy=1", i, bus.Count, bus.busy, 3 + i); end
      @(negedge Clk);
    end
    n_checks++; if ({bus.done, bus.busy, bus.pass_pulse} !== 3'b101 || bus.Count !== 4'd6) begin n_fail++; $display("FAIL up_end got done/busy/pulse=%b count=%0d want 101 count=6", {bus.done, bus.busy, bus.pass_pulse}, bus.Count); end
    @(negedge Clk);
    n_checks++; if (bus.pass_pulse !== 1'b0 || bus.done !== 1'b1) begin n_fail++; $display("FAIL up_pulse_width got pulse=%b done=%b want 0 1", bus.pass_pulse, bus.done); end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd1, 4'd0, 4'd15, 4'd14};
    set_cfg(4'd1, 4'd14, 1'b0, 8'd0, 4'd0);
    pulse_start();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_cleared got %b want 0", bus.done); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.Count !== exp_seq[i] || bus.UpOrDown !== 1'b0) begin n_fail++; $display("FAIL down_seq[%0d] got count=%0d dir=%b want count=%0d dir=0", i, bus.Count, bus.UpOrDown, exp_seq[i]); end
      @(negedge Clk);
    end
    n_checks++; if (bus.done !== 1'b1 || bus.Count !== 4'd14) begin n_fail++; $display("FAIL down_end got done=%b count=%0d want 1 14", bus.done, bus.Count); end
  endtask

  task automatic test_dwell_repeat();
    int pulses = 0;
    set_cfg(4'd0, 4'd2, 1'b1, 8'd2, 4'd1);
    pulse_start();
    for (int k = 0; k < 18; k++) begin
      n_checks++; if (bus.Count !== 4'((k % 9) / 3)) begin n_fail++; $display("FAIL dwell_seq[%0d] got %0d want %0d", k, bus.Count, (k % 9) / 3); end
      n_checks++; if (bus.rep_left !== ((k < 9) ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL dwell_rep[%0d] got %0d want %0d", k, bus.rep_left, (k < 9) ? 1 : 0); end
      n_checks++; if (bus.pass_pulse !== (k == 9)) begin n_fail++; $display("FAIL dwell_pulse[%0d] got %b want %b", k, bus.pass_pulse, k == 9); end
      if (bus.pass_pulse === 1'b1) pulses++;
      @(negedge Clk);
    end
    if (bus.pass_pulse === 1'b1) pulses++;
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL dwell_pulse_count got %0d want 2", pulses); end
    n_checks++; if (bus.done !== 1'b1 || bus.Count !== 4'd2) begin n_fail++; $display("FAIL dwell_end got done=%b count=%0d want 1 2", bus.done, bus.Count); end
  endtask

  task automatic test_single_value();
    set_cfg(4'd7, 4'd7, 1'b1, 8'd1, 4'd1);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.Count !== 4'd7 || bus.pass_pulse !== (k == 2 || k == 4)) begin n_fail++; $display("FAIL single[%0d] got count=%0d pulse=%b want 7 %b", k, bus.Count, bus.pass_pulse, k == 2 || k == 4); end
      n_checks++; if (bus.done !== (k == 4)) begin n_fail++; $display("FAIL single_done[%0d] got %b want %b", k, bus.done, k == 4); end
      @(negedge Clk);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [6];
    int         n_val;
    logic       exp_dir;
`ifdef IIITB_4BBC_SWEEP_BOUNCE_EN
    exp_seq = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd0};
    n_val   = 5;
    exp_dir = 1'b0;
`else
    exp_seq = '{4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4};
    n_val   = 6;
    exp_dir = 1'b1;
`endif
    set_cfg(4'd2, 4'd4, 1'b1, 8'd0, 4'd1);
    pulse_start();
    for (int i = 0; i < n_val; i++) begin
      n_checks++; if (bus.Count !== exp_seq[i]) begin n_fail++; $display("FAIL pass2_seq[%0d] got %0d want %0d", i, bus.Count, exp_seq[i]); end
      @(negedge Clk);
    end
    n_checks++; if (bus.done !== 1'b1 || bus.UpOrDown !== exp_dir) begin n_fail++; $display("FAIL pass2_end got done=%b dir=%b want 1 %b", bus.done, bus.UpOrDown, exp_dir); end
  endtask

  task automatic test_stop();
    set_cfg(4'd0, 4'd15, 1'b1, 8'd0, 4'd0);
    pulse_start();
    for (int n = 0; n < 40 && bus.Count !== 4'd5; n++) @(negedge Clk);
    n_checks++; if (bus.Count !== 4'd5) begin n_fail++; $display("FAIL stop_wait timeout count=%0d want 5", bus.Count); end
    bus.stop = 1'b1;
    @(negedge Clk) bus.stop = 1'b0;
    n_checks++; if ({bus.busy, bus.done, bus.pass_pulse} !== 3'b000 || bus.Count !== 4'd5) begin n_fail++; $display("FAIL stop_abort got busy/done/pulse=%b count=%0d want 000 5", {bus.busy, bus.done, bus.pass_pulse}, bus.Count); end
    @(negedge Clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge Clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    n_checks++; if (bus.busy !== 1'b1 || bus.Count !== 4'd0) begin n_fail++; $display("FAIL start_stop_idle got busy=%b count=%0d want 1 0", bus.busy, bus.Count); end
    bus.stop = 1'b1;
    @(negedge Clk) bus.stop = 1'b0;
    // stop coinciding with the final pass completion
    set_cfg(4'd3, 4'd4, 1'b1, 8'd0, 4'd0);
    pulse_start();
    @(negedge Clk);
    n_checks++; if (bus.Count !== 4'd4) begin n_fail++; $display("FAIL stop_end_setup got %0d want 4", bus.Count); end
    bus.stop = 1'b1;
    @(negedge Clk) bus.stop = 1'b0;
    n_checks++; if ({bus.busy, bus.done, bus.pass_pulse} !== 3'b000) begin n_fail++; $display("FAIL stop_at_end got busy/done/pulse=%b want 000", {bus.busy, bus.done, bus.pass_pulse}); end
  endtask

  task automatic test_reset_midsweep();
    set_cfg(4'd15, 4'd0, 1'b0, 8'd0, 4'd3);
    pulse_start();
    for (int n = 0; n < 40 && bus.Count !== 4'd12; n++) @(negedge Clk);
    n_checks++; if (bus.Count !== 4'd12) begin n_fail++; $display("FAIL run_wait timeout count=%0d want 12", bus.Count); end
    bus.start = 1'b1;
    @(negedge Clk) bus.start = 1'b0;
    n_checks++; if (bus.Count !== 4'd11 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_in_run got count=%0d busy=%b want 11 1", bus.Count, bus.busy); end
    for (int n = 0; n < 40 && bus.Count !== 4'd9; n++) @(negedge Clk);
    n_checks++; if (bus.Count !== 4'd9) begin n_fail++; $display("FAIL reset_wait timeout count=%0d want 9", bus.Count); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.Count !== 4'd0 || bus.UpOrDown !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got count=%0d dir=%b busy=%b want 0 1 0", bus.Count, bus.UpOrDown, bus.busy); end
    n_checks++; if (bus.rep_left !== 4'd0) begin n_fail++; $display("FAIL async_reset_rep got %0d want 0", bus.rep_left); end
    @(negedge Clk) reset_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(4'd0, 4'd0, 1'b1, 8'd0, 4'd0);
    test_reset();
    test_up_sweep();
    test_down_wrap();
    test_dwell_repeat();
    test_single_value();
    test_bounce();
    test_stop();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
